// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes engine: a 128-bit state is substituted through
// BYTES_PER_CYCLE forward S-boxes over 16/BYTES_PER_CYCLE cycles, then held behind valid/ready.

module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254: six square-and-multiply steps reach x^127, one more square gives x^254.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end
endmodule

module sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);
    localparam int B  = BYTES_PER_CYCLE;
    localparam int N  = (B > 0) ? (16 / B) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_param
        $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   out_data_q, out_data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     sb_in  [B];
    logic [7:0]     sb_out [B];

    for (genvar j = 0; j < B; j++) begin : g_sbox
        sbox u_sbox (
            .in_byte  (sb_in[j]),
            .out_byte (sb_out[j])
        );
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        for (int j = 0; j < B; j++) begin
            sb_in[j] = work_q[(int'(cnt_q) * B + j) * 8 +: 8];
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < B; j++) begin
                    work_d[(int'(cnt_q) * B + j) * 8 +: 8] = sb_out[j];
                end
                // With a single slice (N=1) the counter stays at 0 and every BUSY cycle is the last.
                if (cnt_q == CW'(N - 1)) begin
                    out_data_d = work_d;
                    cnt_d      = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: randomized and directed states checked against a
// log/antilog-table model of the AES forward S-box.

module tb_sub_bytes_seq;
    localparam int N = 4;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;

    logic [127:0] sw_in_data = '0;
    logic         sw_in_valid = 1'b0;
    logic [127:0] sw_out_data  [4];
    logic         sw_out_valid [4];
    logic         sw_in_ready  [4];
    logic         sw_busy      [4];

    int cmp = 0;
    int err = 0;

    logic [7:0] exp_t [256];
    logic [7:0] log_t [256];

    always #5 clk = ~clk;

    sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Widths 1, 2, 8, 16 for the sweep; the main instance covers 4.
    for (genvar g = 0; g < 4; g++) begin : g_sw
        sub_bytes_seq #(.BYTES_PER_CYCLE((g < 2) ? (1 << g) : (1 << (g + 1)))) u_sw (
            .clk(clk), .rst(rst), .in_data(sw_in_data), .in_valid(sw_in_valid),
            .in_ready(sw_in_ready[g]), .out_data(sw_out_data[g]), .out_valid(sw_out_valid[g]),
            .out_ready(1'b1), .busy(sw_busy[g])
        );
    end

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_tables();
        logic [7:0] v;
        v = 8'h01;
        log_t[0] = 8'h00;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = v;
            log_t[v] = 8'(i);
            v = v ^ xtime(v);
        end
        exp_t[255] = 8'h01;
    endtask

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c   = 8'h63;
        inv = (b == 8'h00) ? 8'h00 : exp_t[(255 - int'(log_t[b])) % 255];
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        end
        return s;
    endfunction

    function automatic logic [127:0] state_ref(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref(d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    endtask

    // Drives one state (out_ready high) and reports edges from accept to out_valid; lat=-1 on timeout.
    task automatic run_one(input logic [127:0] d, output int lat, output logic [127:0] q);
        wait_idle();
        out_ready = 1'b1;
        in_data   = d;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        q   = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                q   = out_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        cmp++; if (in_ready !== 1'b1)  begin err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        cmp++; if (busy !== 1'b0)      begin err++; $display("FAIL reset_busy got=%b want=0", busy); end
        cmp++; if (out_data !== '0)    begin err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_bytes();
        logic [127:0] pats [4];
        logic [127:0] wants [4];
        logic [127:0] q;
        int lat;
        pats[0] = {16{8'h00}}; wants[0] = {16{8'h63}};
        pats[1] = {16{8'h53}}; wants[1] = {16{8'hed}};
        pats[2] = {16{8'hff}}; wants[2] = {16{8'h16}};
        for (int k = 0; k < 16; k++) pats[3][8*k +: 8] = 8'(k);
        wants[3] = 128'h76abd7fe2b670130c56f6bf27b777c63;
        for (int p = 0; p < 4; p++) begin
            run_one(pats[p], lat, q);
            cmp++; if (q !== wants[p]) begin err++; $display("FAIL single_bytes[%0d] got=%h want=%h", p, q, wants[p]); end
            cmp++; if (q !== state_ref(pats[p])) begin err++; $display("FAIL single_model[%0d] got=%h want=%h", p, q, state_ref(pats[p])); end
        end
    endtask

    task automatic test_fips();
        logic [127:0] q;
        int lat;
        run_one(FIPS_IN, lat, q);
        cmp++; if (q !== FIPS_OUT) begin err++; $display("FAIL fips_data got=%h want=%h", q, FIPS_OUT); end
        cmp++; if (lat !== N)      begin err++; $display("FAIL fips_latency got=%0d want=%0d", lat, N); end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic [127:0] want;
        logic seen;
        d    = rand128();
        want = state_ref(d);
        wait_idle();
        out_ready = 1'b0;
        in_data   = d;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        cmp++; if (out_valid !== 1'b1) begin err++; $display("FAIL bp_reach_done got=%b want=1", out_valid); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_data  = rand128();
            @(posedge clk);
            #1;
            cmp++; if (out_valid !== 1'b1) begin err++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, out_valid); end
            cmp++; if (out_data !== want)  begin err++; $display("FAIL bp_hold_data[%0d] got=%h want=%h", i, out_data, want); end
            cmp++; if (in_ready !== 1'b0)  begin err++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
        cmp++; if (in_ready !== 1'b1)  begin err++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        cmp++; if (out_data !== want)  begin err++; $display("FAIL bp_retain_data got=%h want=%h", out_data, want); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid || busy) seen = 1'b1;
        end
        cmp++; if (seen !== 1'b0) begin err++; $display("FAIL bp_no_second_state got=%b want=0", seen); end
    endtask

    task automatic test_reset_mid_busy();
        logic seen;
        wait_idle();
        in_data  = rand128();
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        cmp++; if (in_ready !== 1'b1)  begin err++; $display("FAIL rst_busy_in_ready got=%b want=1", in_ready); end
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_busy_out_valid got=%b want=0", out_valid); end
        cmp++; if (busy !== 1'b0)      begin err++; $display("FAIL rst_busy_busy got=%b want=0", busy); end
        cmp++; if (out_data !== '0)    begin err++; $display("FAIL rst_busy_out_data got=%h want=0", out_data); end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        cmp++; if (seen !== 1'b0) begin err++; $display("FAIL rst_busy_late_valid got=%b want=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] expq [$];
        logic [127:0] want;
        int sent = 0;
        int got = 0;
        int last = 0;
        logic accepted;
        wait_idle();
        out_ready = 1'b1;
        in_data   = rand128();
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid) begin
                want = (expq.size() > 0) ? expq.pop_front() : '0;
                cmp++; if (out_data !== want) begin err++; $display("FAIL b2b_data[%0d] got=%h want=%h", got, out_data, want); end
                if (got > 0) begin
                    cmp++; if (cyc - last !== N + 2) begin err++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", got, cyc - last, N + 2); end
                end
                last = cyc;
                got++;
            end
            accepted = 1'b0;
            if (in_ready && in_valid) begin
                expq.push_back(state_ref(in_data));
                sent++;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) in_data = rand128();
            if (sent == 8) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        cmp++; if (got !== 8) begin err++; $display("FAIL b2b_count got=%0d want=8", got); end
        cmp++; if (expq.size() !== 0) begin err++; $display("FAIL b2b_leftover got=%0d want=0", expq.size()); end
    endtask

    task automatic test_sweep();
        int lat [4];
        logic [127:0] q [4];
        int want_lat;
        for (int g = 0; g < 4; g++) begin
            lat[g] = -1;
            q[g]   = '0;
        end
        @(negedge clk);
        sw_in_data  = FIPS_IN;
        sw_in_valid = 1'b1;
        @(posedge clk);
        #1 sw_in_valid = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (sw_out_valid[g] && lat[g] < 0) begin
                    lat[g] = i;
                    q[g]   = sw_out_data[g];
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            want_lat = 16 / ((g < 2) ? (1 << g) : (1 << (g + 1)));
            cmp++; if (q[g] !== FIPS_OUT)   begin err++; $display("FAIL sweep_data[%0d] got=%h want=%h", g, q[g], FIPS_OUT); end
            cmp++; if (lat[g] !== want_lat) begin err++; $display("FAIL sweep_latency[%0d] got=%0d want=%0d", g, lat[g], want_lat); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        test_reset();
        test_single_bytes();
        test_fips();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
